clken_pll_gen: RTL and testbench
================================

Name: clken_pll_gen

Overview:
Multi-channel fractional clock-enable generator. It is the parametrised successor to the fixed three-output PLL wrapper. From one fast master clock (refclk) it produces CHANNELS single-cycle enable strobes, each at rate f_refclk*INC[i]/DEN. Per-channel rates are reprogrammable at run time through a valid/ready port, and a settle/lock indicator plus a global phase-align request are provided. Default (refclk 128 MHz, DEN=12, INC={4,1,3}) gives 42.667, 10.667 and 32 MHz enables on channels 2, 1 and 0.

Parameters:
CHANNELS, 3, number of enable channels (1..16)
DEN, 12, common rate denominator (>=1)
NUM_W, $clog2(DEN+1), width of an INC value (derived, not overridden)
CH_W, max(1,$clog2(CHANNELS)), channel index width (derived)
INIT_INC, {4,1,3} packed CHANNELS*NUM_W (ch0 in LSBs), per-channel INC at reset; each entry must be <=DEN
LOCK_CYC, 16, settle cycles before locked asserts (>=1)

Ports:
refclk  in  1  master clock; all logic is on its rising edge
rst  in  1  synchronous, active-high reset
sync_req  in  1  one-cycle request: phase-align all channels
cfg_valid  in  1  config write request
cfg_ready  out  1  config write accepted on an edge where cfg_valid && cfg_ready
cfg_chan  in  CH_W  target channel
cfg_inc  in  NUM_W  new INC for cfg_chan
cfg_err  out  1  one-cycle pulse: accepted write was illegal and ignored
ce  out  CHANNELS  per-channel enable strobes, registered
locked  out  1  high once rates are stable for LOCK_CYC cycles

Behaviour:
- Reset (rst high at an edge):
  - acc[i]=0, inc[i]=INIT_INC[i], ce=0, cfg_err=0, locked=0, cfg_ready=0.
  - State=SETTLE, lock_cnt=LOCK_CYC.
  - rst is sampled every edge; asserting it mid-operation aborts any write or settle immediately.
- Accumulator, each channel, every non-reset edge not overridden by sync/write:
  - s = acc+inc, computed in $clog2(2*DEN) bits with no overflow.
  - If s>=DEN: acc<=s-DEN, ce[i]<=1. Else: acc<=s, ce[i]<=0.
  - Accumulators and strobes run in all states; locked is only an indicator.
- Boundary cases:
  - inc=0: ce[i] is never asserted.
  - inc=DEN: ce[i] is high every cycle.
  - Long-run strobe count over DEN cycles is exactly inc, with no drift.
- State machine:
  - SETTLE: cfg_ready=1, locked=0. lock_cnt decrements each edge; when it reaches 1, go to LOCKED, so locked is high on the LOCK_CYC-th edge after entry.
  - LOCKED: cfg_ready=1, locked=1.
  - APPLY: exactly one cycle after an accepted write. cfg_ready=0, locked=0, then go to SETTLE with lock_cnt=LOCK_CYC.
- Config write (cfg_valid && cfg_ready, state SETTLE or LOCKED):
  - Legal (cfg_chan<CHANNELS and cfg_inc<=DEN): on that edge inc[chan]<=cfg_inc, acc[chan]<=0, ce[chan]<=0; other channels are untouched. Go to APPLY; locked falls on the same edge.
  - Illegal: cfg_err=1 for one cycle, no state change, locked is unaffected.
- sync_req (edge with rst low):
  - All acc<=0 and ce<=0; inc is unchanged.
  - State<=SETTLE, lock_cnt<=LOCK_CYC, locked<=0.
  - sync_req has priority over the write path: if it coincides with cfg_valid, the write is NOT accepted that edge (cfg_ready is forced low combinationally while sync_req=1) and the requester must hold cfg_valid.
  - sync_req during APPLY is honoured in the same way.
- The first strobe after any accumulator clear comes on the ceil(DEN/inc)-th following edge.
- cfg_err is 0 in every cycle other than the pulse.

Test Plan:
- Reset with defaults, release rst -> ce[2] high on edges 3,6,9…, ce[1] on 12,24…, ce[0] on 4,8,12…; locked rises on edge 16 after release.
- Legal write chan=1 inc=6 while LOCKED -> cfg_ready low one cycle, locked falls and is high again 17 edges after accept, ce[1] then pulses every 2 edges; ch0/ch2 timing undisturbed.
- Illegal writes chan=3, and chan=0 inc=13 -> cfg_err single pulse each; inc and locked unchanged, cfg_ready stays 1.
- inc=0 on ch2 -> ce[2] stays 0 for 100 cycles; inc=12 on ch0 -> ce[0] high every cycle.
- sync_req coinciding with cfg_valid -> all acc cleared, write not accepted that edge, accepted next edge with cfg_valid held; all channels restart aligned (ce[0] and ce[2] both high on edge 12).
- rst asserted during APPLY and during SETTLE -> all outputs at reset values next edge, inc restored to INIT_INC.

Source files
------------

// File: rtl/clken_pll_gen.sv
// Multi-channel fractional clock-enable generator: channel i strobes at f_refclk*inc[i]/DEN,
// with run-time rate writes, a settle/lock indicator and a global phase-align request.
module clken_pll_gen #(
    parameter int CHANNELS = 3,
    parameter int DEN = 12,
    parameter int NUM_W = $clog2(DEN + 1),
    parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter logic [CHANNELS*NUM_W-1:0] INIT_INC = {4'd4, 4'd1, 4'd3},
    parameter int LOCK_CYC = 16
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                sync_req,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [NUM_W-1:0]    cfg_inc,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] ce,
    output logic                locked
);
    localparam int ACC_W = $clog2(2 * DEN);
    localparam int CNT_W = $clog2(LOCK_CYC + 1);

    typedef enum logic [1:0] {SETTLE, LOCKED, APPLY} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [ACC_W-1:0]    acc_q [CHANNELS];
    logic [ACC_W-1:0]    acc_d [CHANNELS];
    logic [ACC_W-1:0]    sum   [CHANNELS];
    logic [NUM_W-1:0]    inc_q [CHANNELS];
    logic [NUM_W-1:0]    inc_d [CHANNELS];
    logic [CHANNELS-1:0] ce_q, ce_d;
    logic                locked_q, locked_d;
    logic                cfg_err_q, cfg_err_d;
    logic                wr_fire, wr_legal;

    // A phase-align request steals the cycle, so the writer must hold cfg_valid.
    assign cfg_ready = !rst && !sync_req && (state_q != APPLY);
    assign wr_fire   = cfg_valid && cfg_ready;
    assign wr_legal  = (int'(cfg_chan) < CHANNELS) && (cfg_inc <= NUM_W'(DEN));

    assign ce      = ce_q;
    assign locked  = locked_q;
    assign cfg_err = cfg_err_q;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        cfg_err_d  = 1'b0;
        ce_d       = '0;

        for (int i = 0; i < CHANNELS; i++) begin
            inc_d[i] = inc_q[i];
            sum[i]   = acc_q[i] + ACC_W'(inc_q[i]);
            if (sum[i] >= ACC_W'(DEN)) begin
                acc_d[i] = sum[i] - ACC_W'(DEN);
                ce_d[i]  = 1'b1;
            end else begin
                acc_d[i] = sum[i];
            end
        end

        case (state_q)
            SETTLE: begin
                locked_d = 1'b0;
                if (lock_cnt_q == CNT_W'(1)) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q - CNT_W'(1);
                end
            end
            LOCKED: locked_d = 1'b1;
            APPLY: begin
                state_d    = SETTLE;
                lock_cnt_d = CNT_W'(LOCK_CYC);
                locked_d   = 1'b0;
            end
            default: begin
                state_d    = SETTLE;
                lock_cnt_d = CNT_W'(LOCK_CYC);
                locked_d   = 1'b0;
            end
        endcase

        if (sync_req) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_d[i] = '0;
            end
            ce_d       = '0;
            state_d    = SETTLE;
            lock_cnt_d = CNT_W'(LOCK_CYC);
            locked_d   = 1'b0;
        end else if (wr_fire) begin
            if (wr_legal) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (i == int'(cfg_chan)) begin
                        inc_d[i] = cfg_inc;
                        acc_d[i] = '0;
                        ce_d[i]  = 1'b0;
                    end
                end
                state_d  = APPLY;
                locked_d = 1'b0;
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= SETTLE;
            lock_cnt_q <= CNT_W'(LOCK_CYC);
            locked_q   <= 1'b0;
            cfg_err_q  <= 1'b0;
            ce_q       <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= '0;
                inc_q[i] <= INIT_INC[i*NUM_W +: NUM_W];
            end
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
            cfg_err_q  <= cfg_err_d;
            ce_q       <= ce_d;
            for (int i = 0; i < CHANNELS; i++) begin
                acc_q[i] <= acc_d[i];
                inc_q[i] <= inc_d[i];
            end
        end
    end
endmodule

// File: tb/tb_clken_pll_gen.sv
// Scoreboard bench for clken_pll_gen: the driver pushes expected outputs from an
// edge-count reference model, the monitor pops and compares one record per clock edge.
module tb_clken_pll_gen;
    localparam int CHANNELS = 3;
    localparam int DEN = 12;
    localparam int NUM_W = 4;
    localparam int CH_W = 2;
    localparam int LOCK_CYC = 16;
    localparam logic [CHANNELS*NUM_W-1:0] INIT_INC = {4'd4, 4'd1, 4'd3};

    logic                refclk = 1'b0;
    logic                rst = 1'b1;
    logic                sync_req = 1'b0;
    logic                cfg_valid = 1'b0;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_chan = '0;
    logic [NUM_W-1:0]    cfg_inc = '0;
    logic                cfg_err;
    logic [CHANNELS-1:0] ce;
    logic                locked;

    always #5 refclk = ~refclk;

    clken_pll_gen #(
        .CHANNELS(CHANNELS),
        .DEN(DEN),
        .INIT_INC(INIT_INC),
        .LOCK_CYC(LOCK_CYC)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .sync_req(sync_req),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan),
        .cfg_inc(cfg_inc),
        .cfg_err(cfg_err),
        .ce(ce),
        .locked(locked)
    );

    typedef struct packed {
        logic [CHANNELS-1:0] ce;
        logic                locked;
        logic                err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   checks = 0;
    int   miscompares = 0;

    // Reference model: edges since last clear per channel, and edges left until lock.
    longint m_n[CHANNELS];
    int     m_inc[CHANNELS];
    int     m_settle;
    bit     m_apply;

    function automatic bit strobe(input longint n, input int inc);
        return ((n * inc) / DEN) > (((n - 1) * inc) / DEN);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit s, input bit v, input int ch, input int inc);
        exp_t e;
        bit   rdy;
        logic [CHANNELS*NUM_W-1:0] init_v;
        @(negedge refclk);
        rst       = r;
        sync_req  = s;
        cfg_valid = v;
        cfg_chan  = ch[CH_W-1:0];
        cfg_inc   = inc[NUM_W-1:0];
        vectors++;
        #1;
        rdy = !r && !s && !m_apply;
        checkOutput("cfg_ready", {31'd0, cfg_ready}, {31'd0, rdy});

        e = '0;
        init_v = INIT_INC;
        if (r) begin
            for (int i = 0; i < CHANNELS; i++) begin
                m_n[i]   = 0;
                m_inc[i] = int'(init_v[i*NUM_W +: NUM_W]);
            end
            m_settle = LOCK_CYC;
            m_apply  = 1'b0;
        end else if (s) begin
            for (int i = 0; i < CHANNELS; i++) m_n[i] = 0;
            m_settle = LOCK_CYC;
            m_apply  = 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                m_n[i]++;
                e.ce[i] = strobe(m_n[i], m_inc[i]);
            end
            if (m_apply) begin
                m_apply  = 1'b0;
                m_settle = LOCK_CYC;
            end else if (m_settle > 0) begin
                m_settle--;
            end
            if (v && rdy) begin
                if (ch < CHANNELS && inc <= DEN) begin
                    m_inc[ch] = inc;
                    m_n[ch]   = 0;
                    e.ce[ch]  = 1'b0;
                    m_apply   = 1'b1;
                end else begin
                    e.err = 1'b1;
                end
            end
            e.locked = !m_apply && (m_settle == 0);
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    // Holds cfg_valid until the model says the write can be taken.
    task automatic writeCfg(input int ch, input int inc);
        int tries;
        tries = 0;
        while (m_apply && tries < 8) begin
            applyStimulus(1'b0, 1'b0, 1'b1, ch, inc);
            tries++;
        end
        applyStimulus(1'b0, 1'b0, 1'b1, ch, inc);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge refclk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("ce", {29'd0, ce}, {29'd0, e.ce});
                checkOutput("locked", {31'd0, locked}, {31'd0, e.locked});
                checkOutput("cfg_err", {31'd0, cfg_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        bit r, s, v;
        int ch, inc, waited;
        for (int i = 0; i < CHANNELS; i++) begin
            m_n[i]   = 0;
            m_inc[i] = 0;
        end
        m_settle = LOCK_CYC;
        m_apply  = 1'b0;

        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        idle(40);

        writeCfg(1, 6);
        idle(30);

        writeCfg(3, 5);
        idle(3);
        writeCfg(0, 13);
        idle(3);

        writeCfg(2, 0);
        idle(100);
        writeCfg(0, 12);
        idle(20);

        writeCfg(2, 4);
        writeCfg(0, 3);
        idle(20);
        applyStimulus(1'b0, 1'b1, 1'b1, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1, 1);
        idle(30);

        writeCfg(1, 7);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        idle(5);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0);
        idle(20);

        for (int k = 0; k < 2000; k++) begin
            r   = ($urandom_range(0, 299) == 0);
            s   = ($urandom_range(0, 59) == 0);
            v   = ($urandom_range(0, 5) == 0);
            ch  = $urandom_range(0, 3);
            inc = ($urandom_range(0, 9) != 0) ? $urandom_range(0, DEN) : $urandom_range(0, 15);
            applyStimulus(r, s, v, ch, inc);
        end
        idle(5);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge refclk);
            #2;
            waited++;
        end
        checkOutput("scoreboard_drain", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
